mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single unified memory port between instruction-cache miss traffic (read-only) and data-cache miss/write-through traffic (read/write).
- Sits between the two cache blocks and the memory/IP wrapper, and serialises their requests.
- Enforces a fixed read latency and data-side priority, with a starvation guard so instruction fetch always makes progress.

Parameters:
ADDR_W, 32, address width of all address ports
DATA_W, 32, data width of all data ports
RD_LATENCY, 2, cycles from mem_addr presentation to valid mem_rdata (legal range 1..15)
STARVE_LIMIT, 4, max consecutive D grants while i_req is pending before I is forced (1..15)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
i_req  in  1  instruction-side read request, held until i_ready
i_addr  in  ADDR_W  instruction-side word address
i_ready  out  1  one-cycle pulse: I transaction complete, i_rdata valid
i_rdata  out  DATA_W  instruction read data, registered
d_req  in  1  data-side request, held until d_ready
d_we  in  1  1 = write, 0 = read
d_addr  in  ADDR_W  data-side address
d_wdata  in  DATA_W  data-side write data (already byte-merged)
d_ready  out  1  one-cycle pulse: D transaction complete
d_rdata  out  DATA_W  data read data, registered
mem_addr  out  ADDR_W  address to memory
mem_wdata  out  DATA_W  write data to memory
mem_we  out  1  memory write strobe
mem_rdata  in  DATA_W  memory read data
busy  out  1  1 whenever state != IDLE
owner  out  1  0 = I, 1 = D; meaningful only while busy

Behaviour:
- Reset (async): state=IDLE, streak=0, latency counter=0, all outputs 0 (i_ready, d_ready, mem_we, busy, owner, mem_addr, mem_wdata, i_rdata, d_rdata).
- Reset mid-transaction aborts the transaction. No ready pulse is issued and requesters reissue after reset.
- States: IDLE, WAIT, DONE.
- IDLE, no req: stay.
- IDLE, any req: arbitrate, latch addr/we/wdata/owner, go to WAIT.
  - Read: load cnt = RD_LATENCY-1.
  - Write: load cnt = 0.
- Arbitration when only one req is high: that side wins.
- Arbitration when both reqs are high:
  - D wins if streak < STARVE_LIMIT; streak increments.
  - Otherwise I wins and streak clears.
- Streak also clears on any grant taken while i_req is low, and on any I grant.
- WAIT:
  - mem_addr drives the latched address; mem_wdata drives the latched wdata.
  - mem_we = 1 only for a D write, and only in its single WAIT cycle; otherwise 0.
  - Read: if cnt == 0, capture mem_rdata into the owner's rdata register and go to DONE; else decrement cnt.
  - Write: go to DONE after one cycle.
- DONE: pulse the owner's ready for exactly one cycle, then go to IDLE. The non-owner's ready stays 0.
- A req still high in IDLE after DONE is treated as a new request. The minimum gap between ready pulses is therefore one IDLE cycle.
- Latency, request first seen in IDLE at cycle 0:
  - Read: ready at cycle RD_LATENCY+1, mem_rdata sampled at end of cycle RD_LATENCY.
  - Write: mem_we at cycle 1, ready at cycle 2.
- d_rdata is unchanged by writes. Each rdata register holds its value until the next read by that side.
- Inputs changing during WAIT are ignored, since operands are latched. A req dropped mid-transaction still completes and still pulses ready.
- mem_addr/mem_wdata hold their last value in IDLE/DONE. mem_we is never 1 outside WAIT.

Test Plan:
- I read only, RD_LATENCY=2, i_addr=0x0000_0040, mem returns 0xDEAD_BEEF at cycle 2 -> i_ready=1 only at cycle 3, i_rdata=0xDEAD_BEEF, d_ready stays 0, mem_we stays 0.
- i_req and d_req rise together (d_we=0, d_addr=0x100; i_addr=0x200) -> D granted first: owner=1, mem_addr=0x100, d_ready at cycle 3. I granted at cycle 4 (IDLE), i_ready at cycle 7.
- D write d_addr=0x80, d_wdata=0x1234_5678 -> mem_we=1 only at cycle 1 with mem_addr=0x80 and mem_wdata=0x1234_5678; d_ready at cycle 2; d_rdata unchanged.
- Starvation, STARVE_LIMIT=4, d_req and i_req held high continuously -> grants are D,D,D,D,I,D,D,D,D,I; streak resets after each I grant.
- rst asserted during a read's WAIT cycle -> same cycle: busy=0, mem_we=0, no ready pulse. After release with i_req still high -> fresh I transaction starts and completes normally.
- RD_LATENCY=1, back-to-back I reads with i_req held -> i_ready pulses every 3 cycles, each carrying the mem_rdata of its own transaction.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one memory port between I-cache reads and D-cache reads/writes.
// Data side has priority; a streak counter forces an I grant after STARVE_LIMIT D grants.
module mem_port_arbiter #(
   parameter int ADDR_W       = 32,
   parameter int DATA_W       = 32,
   parameter int RD_LATENCY   = 2,
   parameter int STARVE_LIMIT = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   output logic              i_ready,
   output logic [DATA_W-1:0] i_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_ready,
   output logic [DATA_W-1:0] d_rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_we,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy,
   output logic              owner
);

   typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

   localparam logic [3:0] RD_LOAD    = 4'(RD_LATENCY - 1);
   localparam logic [3:0] STREAK_MAX = 4'(STARVE_LIMIT);

   state_t            state_reg, state_next;
   logic [3:0]        cnt_reg, cnt_next;
   logic [3:0]        streak_reg, streak_next;
   logic [ADDR_W-1:0] addr_reg, addr_next;
   logic [DATA_W-1:0] wdata_reg, wdata_next;
   logic              we_reg, we_next;
   logic              owner_reg, owner_next;
   logic [DATA_W-1:0] i_rdata_reg, d_rdata_reg;
   logic              grant_d;
   logic              capture;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg   <= IDLE;
         cnt_reg     <= '0;
         streak_reg  <= '0;
         addr_reg    <= '0;
         wdata_reg   <= '0;
         we_reg      <= 1'b0;
         owner_reg   <= 1'b0;
         i_rdata_reg <= '0;
         d_rdata_reg <= '0;
      end else begin
         state_reg  <= state_next;
         cnt_reg    <= cnt_next;
         streak_reg <= streak_next;
         addr_reg   <= addr_next;
         wdata_reg  <= wdata_next;
         we_reg     <= we_next;
         owner_reg  <= owner_next;
         if (capture && !owner_reg) i_rdata_reg <= mem_rdata;
         if (capture && owner_reg)  d_rdata_reg <= mem_rdata;
      end
   end

   always_comb begin
      state_next  = state_reg;
      cnt_next    = cnt_reg;
      streak_next = streak_reg;
      addr_next   = addr_reg;
      wdata_next  = wdata_reg;
      we_next     = we_reg;
      owner_next  = owner_reg;
      grant_d     = 1'b0;
      capture     = 1'b0;
      case (state_reg)
         IDLE: begin
            if (i_req || d_req) begin
               // D wins unless I is waiting and D has used up its streak
               grant_d    = d_req && (!i_req || (streak_reg < STREAK_MAX));
               owner_next = grant_d;
               state_next = WAIT;
               if (grant_d) begin
                  addr_next  = d_addr;
                  wdata_next = d_wdata;
                  we_next    = d_we;
                  cnt_next   = d_we ? 4'd0 : RD_LOAD;
               end else begin
                  addr_next = i_addr;
                  we_next   = 1'b0;
                  cnt_next  = RD_LOAD;
               end
               streak_next = (grant_d && i_req) ? streak_reg + 4'd1 : 4'd0;
            end
         end
         WAIT: begin
            if (we_reg) begin
               state_next = DONE;
            end else if (cnt_reg == 4'd0) begin
               capture    = 1'b1;
               state_next = DONE;
            end else begin
               cnt_next = cnt_reg - 4'd1;
            end
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Decoded from state so an async reset clears them in the same cycle
   assign busy      = (state_reg != IDLE);
   assign owner     = owner_reg;
   assign mem_we    = (state_reg == WAIT) && we_reg;
   assign i_ready   = (state_reg == DONE) && !owner_reg;
   assign d_ready   = (state_reg == DONE) && owner_reg;
   assign mem_addr  = addr_reg;
   assign mem_wdata = wdata_reg;
   assign i_rdata   = i_rdata_reg;
   assign d_rdata   = d_rdata_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: latency, priority, starvation guard, reset abort.
// A second instance with RD_LATENCY=1 covers back-to-back short reads.
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_req, d_req, d_we, mem_we, busy, owner, i_ready, d_ready;
   logic [31:0] i_addr, d_addr, d_wdata, i_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;

   logic        i_req1, i_ready1, d_ready1, mem_we1, busy1, owner1;
   logic [31:0] i_addr1, i_rdata1, d_rdata1, mem_addr1, mem_wdata1, mem_rdata1;
   logic        d_req1 = 1'b0, d_we1 = 1'b0;
   logic [31:0] d_addr1 = '0, d_wdata1 = '0;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LATENCY(2), .STARVE_LIMIT(4)) dut (
      .clk(clk), .rst(rst),
      .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready), .i_rdata(i_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_ready(d_ready), .d_rdata(d_rdata),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
      .busy(busy), .owner(owner)
   );

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LATENCY(1), .STARVE_LIMIT(4)) dut1 (
      .clk(clk), .rst(rst),
      .i_req(i_req1), .i_addr(i_addr1), .i_ready(i_ready1), .i_rdata(i_rdata1),
      .d_req(d_req1), .d_we(d_we1), .d_addr(d_addr1), .d_wdata(d_wdata1),
      .d_ready(d_ready1), .d_rdata(d_rdata1),
      .mem_addr(mem_addr1), .mem_wdata(mem_wdata1), .mem_we(mem_we1), .mem_rdata(mem_rdata1),
      .busy(busy1), .owner(owner1)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [9:0] exp_grants;
      logic       prev_busy;
      int         n;
      int         cyc;

      rst = 1'b1;
      i_req = 0; i_addr = '0; d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
      i_req1 = 0; i_addr1 = '0; mem_rdata1 = '0;
      tick(); tick(); tick();
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_ready", {30'd0, i_ready, d_ready}, 32'd0);
      check("rst_mem_we", 32'(mem_we), 32'd0);
      check("rst_mem_addr", mem_addr, 32'd0);
      check("rst_owner", 32'(owner), 32'd0);
      check("rst_i_rdata", i_rdata, 32'd0);
      rst = 1'b0;

      // I read alone; memory data only valid in cycle 2
      i_req = 1; i_addr = 32'h0000_0040;
      for (int c = 0; c <= 4; c++) begin
         mem_rdata = (c == 2) ? 32'hDEAD_BEEF : 32'h0;
         check($sformatf("t1_i_ready_c%0d", c), 32'(i_ready), 32'(c == 3));
         check($sformatf("t1_d_ready_c%0d", c), 32'(d_ready), 32'd0);
         check($sformatf("t1_mem_we_c%0d", c), 32'(mem_we), 32'd0);
         if (c == 1) check("t1_mem_addr", mem_addr, 32'h40);
         if (c == 3) begin
            check("t1_i_rdata", i_rdata, 32'hDEAD_BEEF);
            $display("txn I read addr=%h rdata=%h", 32'h40, i_rdata);
            i_req = 0;
         end
         tick();
      end

      // Simultaneous requests: D first, then I
      d_req = 1; d_we = 0; d_addr = 32'h100; i_req = 1; i_addr = 32'h200;
      for (int c = 0; c <= 8; c++) begin
         mem_rdata = 32'hC000_0000 | 32'(c);
         check($sformatf("t2_d_ready_c%0d", c), 32'(d_ready), 32'(c == 3));
         check($sformatf("t2_i_ready_c%0d", c), 32'(i_ready), 32'(c == 7));
         if (c == 1) begin
            check("t2_owner_d", 32'(owner), 32'd1);
            check("t2_addr_d", mem_addr, 32'h100);
         end
         if (c == 4) check("t2_idle_gap", 32'(busy), 32'd0);
         if (c == 5) begin
            check("t2_owner_i", 32'(owner), 32'd0);
            check("t2_addr_i", mem_addr, 32'h200);
         end
         if (c == 3) begin
            $display("txn D read addr=%h rdata=%h", 32'h100, d_rdata);
            d_req = 0;
         end
         if (c == 7) begin
            $display("txn I read addr=%h rdata=%h", 32'h200, i_rdata);
            i_req = 0;
         end
         tick();
      end
      check("t2_d_rdata", d_rdata, 32'hC000_0002);
      check("t2_i_rdata", i_rdata, 32'hC000_0006);

      // D write: strobe for one cycle, read data untouched
      d_req = 1; d_we = 1; d_addr = 32'h80; d_wdata = 32'h1234_5678; mem_rdata = 32'hFFFF_FFFF;
      for (int c = 0; c <= 3; c++) begin
         check($sformatf("t3_mem_we_c%0d", c), 32'(mem_we), 32'(c == 1));
         check($sformatf("t3_d_ready_c%0d", c), 32'(d_ready), 32'(c == 2));
         if (c == 1) begin
            check("t3_mem_addr", mem_addr, 32'h80);
            check("t3_mem_wdata", mem_wdata, 32'h1234_5678);
         end
         if (c == 2) begin
            $display("txn D write addr=%h wdata=%h", 32'h80, 32'h1234_5678);
            d_req = 0;
         end
         if (c == 3) check("t3_d_rdata_kept", d_rdata, 32'hC000_0002);
         tick();
      end

      // Starvation guard: both held high, grant order D,D,D,D,I repeating (bit 9 first)
      exp_grants = 10'b11110_11110;
      d_req = 1; d_we = 0; d_addr = 32'h500; i_req = 1; i_addr = 32'h600;
      prev_busy = 1'b0; n = 0; cyc = 0;
      while (n < 10 && cyc < 80) begin
         if (busy && !prev_busy) begin
            check($sformatf("t4_grant%0d", n), 32'(owner), 32'(exp_grants[9-n]));
            $display("txn grant %0d owner=%s", n, owner ? "D" : "I");
            n++;
         end
         prev_busy = busy;
         tick();
         cyc++;
      end
      check("t4_grant_count", 32'(n), 32'd10);
      d_req = 0; i_req = 0;
      for (int k = 0; k < 6; k++) tick();

      // Reset during WAIT aborts; held request restarts cleanly
      i_req = 1; i_addr = 32'h300; mem_rdata = 32'h0;
      tick();
      check("t5_busy_pre", 32'(busy), 32'd1);
      rst = 1'b1;
      #1;
      check("t5_busy_rst", 32'(busy), 32'd0);
      check("t5_mem_we_rst", 32'(mem_we), 32'd0);
      check("t5_ready_rst", {30'd0, i_ready, d_ready}, 32'd0);
      tick();
      rst = 1'b0;
      check("t5_i_rdata_cleared", i_rdata, 32'd0);
      for (int c = 0; c <= 4; c++) begin
         mem_rdata = 32'hA000_0000 | 32'(c);
         check($sformatf("t5_i_ready_c%0d", c), 32'(i_ready), 32'(c == 3));
         if (c == 1) check("t5_mem_addr", mem_addr, 32'h300);
         if (c == 3) begin
            check("t5_i_rdata", i_rdata, 32'hA000_0002);
            $display("txn I read after reset addr=%h rdata=%h", 32'h300, i_rdata);
            i_req = 0;
         end
         tick();
      end

      // RD_LATENCY=1, I held: ready every 3 cycles, data from its own WAIT cycle
      i_req1 = 1; i_addr1 = 32'h700;
      for (int c = 0; c <= 9; c++) begin
         mem_rdata1 = 32'hB000_0000 | 32'(c);
         check($sformatf("t6_i_ready_c%0d", c), 32'(i_ready1), 32'((c % 3) == 2));
         if ((c % 3) == 2) begin
            check($sformatf("t6_i_rdata_c%0d", c), i_rdata1, 32'hB000_0000 | 32'(c - 1));
            $display("txn I read lat1 cycle=%0d rdata=%h", c, i_rdata1);
         end
         tick();
      end
      i_req1 = 0;
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
